// File: rtl/data_scratchpad.sv
// -----------------------------------------------------------------------------
// data_scratchpad
//
// Single-port, word-addressed scratchpad SRAM acting as the responder on the
// LSU memory interface. One request is accepted at a time. The array access
// happens LATENCY edges after acceptance, and the result is signalled with a
// one-cycle mem_ready pulse. Misaligned or out-of-window accesses complete
// with mem_error=1 and do not touch the array.
//
// Optional feature macro: SCRATCHPAD_PERF_CNT_EN
//   When this macro is defined, the module adds the 32-bit counters
//   perf_rd_cnt, perf_wr_cnt and perf_err_cnt.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   mem_req      in   request valid (held by initiator until mem_ready)
//   mem_we       in   1 = write, 0 = read (sampled at acceptance)
//   mem_addr     in   byte address (sampled at acceptance)
//   mem_wdata    in   write data (sampled at acceptance)
//   mem_ready    out  one-cycle completion pulse
//   mem_rdata    out  read data, valid while mem_ready=1, otherwise 0
//   mem_error    out  access fault, only high while mem_ready=1
//   perf_*_cnt   out  completed read / write / fault counts (macro only)
// -----------------------------------------------------------------------------
module data_scratchpad #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int              LATENCY     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            mem_ready,
  output logic [XLEN-1:0] mem_rdata,
`ifdef SCRATCHPAD_PERF_CNT_EN
  output logic            mem_error,
  output logic [31:0]     perf_rd_cnt,
  output logic [31:0]     perf_wr_cnt,
  output logic [31:0]     perf_err_cnt
`else
  output logic            mem_error
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // The window size is held one bit wider than XLEN so that a window that
  // covers the whole address space still compares correctly.
  localparam logic [XLEN:0] LP_WINDOW   = (XLEN+1)'(DEPTH_WORDS) << 2;
  localparam logic [3:0]    LP_CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_mem [DEPTH_WORDS];

  logic [XLEN-1:0]   w_off;
  logic              w_valid;
  logic [AW-1:0]     w_idx;
  logic              w_access;

  // Decode the latched address. An address below BASE_ADDR wraps to a huge
  // offset and therefore fails the window check.
  assign w_off    = r_addr - BASE_ADDR;
  assign w_valid  = (r_addr[1:0] == 2'b00) && ({1'b0, w_off} < LP_WINDOW);
  assign w_idx    = w_off[AW+1:2];
  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);

  // Request capture. These registers need no reset: they are only consumed
  // after a fresh acceptance has overwritten them.
  // NOTE: all sequential state uses non-blocking assignments so every
  // always_ff reads the pre-edge values, whatever the process order.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && mem_req) begin
      r_we    <= mem_we;
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
    end
  end

  // Array write port. A reset on the write edge itself aborts the write.
  // NOTE: the array is deliberately left out of reset so it maps onto SRAM
  // macros; contents survive a reset.
  always_ff @(posedge clk) begin
    if (!reset && w_access && r_we && w_valid) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_cnt   <= LP_CNT_INIT;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            mem_ready <= 1'b1;
            r_state   <= RESP;
            if (!w_valid) begin
              mem_error <= 1'b1;
              mem_rdata <= '0;
            end else if (r_we) begin
              mem_error <= 1'b0;
              mem_rdata <= '0;
            end else begin
              mem_error <= 1'b0;
              mem_rdata <= r_mem[w_idx];
            end
          end
        end
        RESP: begin
          // mem_req is intentionally not sampled here, so a request still
          // held high on this edge is not accepted a second time.
          mem_ready <= 1'b0;
          mem_error <= 1'b0;
          mem_rdata <= '0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef SCRATCHPAD_PERF_CNT_EN
  // Counters advance on the same edge that raises mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_err_cnt <= '0;
    end else if (w_access) begin
      if (!w_valid) begin
        perf_err_cnt <= perf_err_cnt + 32'd1;
      end else if (r_we) begin
        perf_wr_cnt  <= perf_wr_cnt + 32'd1;
      end else begin
        perf_rd_cnt  <= perf_rd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_scratchpad.sv
// -----------------------------------------------------------------------------
// tb_data_scratchpad
//
// Directed testbench for data_scratchpad. Instance 0 uses LATENCY=1 and
// instance 1 uses LATENCY=3. Both instances share the clock and the reset.
// The bench hand-computes every expected value.
// -----------------------------------------------------------------------------
module tb_data_scratchpad;

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       ready;
  logic [1:0]       error;
  logic [1:0][31:0] rdata;
`ifdef SCRATCHPAD_PERF_CNT_EN
  logic [1:0][31:0] prd;
  logic [1:0][31:0] pwr;
  logic [1:0][31:0] perr;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  data_scratchpad #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) u_dut0 (
    .clk       (clk),
    .reset     (rst),
    .mem_req   (req[0]),
    .mem_we    (we[0]),
    .mem_addr  (addr[0]),
    .mem_wdata (wdata[0]),
    .mem_ready (ready[0]),
    .mem_rdata (rdata[0]),
`ifdef SCRATCHPAD_PERF_CNT_EN
    .mem_error   (error[0]),
    .perf_rd_cnt (prd[0]),
    .perf_wr_cnt (pwr[0]),
    .perf_err_cnt(perr[0])
`else
    .mem_error (error[0])
`endif
  );

  data_scratchpad #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) u_dut1 (
    .clk       (clk),
    .reset     (rst),
    .mem_req   (req[1]),
    .mem_we    (we[1]),
    .mem_addr  (addr[1]),
    .mem_wdata (wdata[1]),
    .mem_ready (ready[1]),
    .mem_rdata (rdata[1]),
`ifdef SCRATCHPAD_PERF_CNT_EN
    .mem_error   (error[1]),
    .perf_rd_cnt (prd[1]),
    .perf_wr_cnt (pwr[1]),
    .perf_err_cnt(perr[1])
`else
    .mem_error (error[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Runs one transaction on instance d. lat is the number of edges between
  // acceptance and the edge that raises mem_ready. With toggle set, the
  // address, direction and data are changed while the request is in flight.
  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input bit toggle,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    n   = 0;
    rd  = '0;
    er  = 1'b0;
    lat = -1;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    while (lat < 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready[d]) begin
        lat = n - 1;
        rd  = rdata[d];
        er  = error[d];
      end else if (toggle) begin
        addr[d]  = a ^ 32'h4;
        we[d]    = ~w;
        wdata[d] = 32'hDEAD_BEEF;
      end
    end
    req[d] = 1'b0; we[d] = 1'b0;
    if (lat < 0) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      check("ready_fall", 32'(ready[d]), 32'd0);
      check("error_fall", 32'(error[d]), 32'd0);
      check("rdata_fall", rdata[d], 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    int          last_edge;

    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(ready[d]), 32'd0);
      check("rst_error", 32'(error[d]), 32'd0);
      check("rst_rdata", rdata[d], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=1 write then read-back.
    txn(0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0, rd, er, lat);
    check("l1_wr_lat", 32'(lat), 32'd1);
    check("l1_wr_rdata", rd, 32'd0);
    check("l1_wr_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
    check("l1_rd_lat", 32'(lat), 32'd1);
    check("l1_rd_rdata", rd, 32'hCAFE_F00D);
    check("l1_rd_err", 32'(er), 32'd0);

    // LATENCY=3: the request bus changes during BUSY and must be ignored.
    txn(1, 1'b1, 32'h8, 32'h1111_1111, 1'b0, rd, er, lat);
    txn(1, 1'b1, 32'hC, 32'h2222_2222, 1'b0, rd, er, lat);
    txn(1, 1'b0, 32'h8, 32'h0, 1'b1, rd, er, lat);
    check("l3_rd_lat", 32'(lat), 32'd3);
    check("l3_rd_rdata", rd, 32'h1111_1111);
    txn(1, 1'b0, 32'hC, 32'h0, 1'b0, rd, er, lat);
    check("l3_neighbour", rd, 32'h2222_2222);

    // Faults: out of range, wrapped MMIO, misaligned; the array stays untouched.
    txn(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 1'b0, rd, er, lat);
    txn(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 1'b0, rd, er, lat);
    check("oor_wr_err", 32'(er), 32'd1);
    check("oor_wr_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'hF000_0004, 32'h0, 1'b0, rd, er, lat);
    check("mmio_rd_err", 32'(er), 32'd1);
    check("mmio_rd_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat);
    check("word0_kept", rd, 32'hA5A5_A5A5);
    check("word0_err", 32'(er), 32'd0);
    txn(0, 1'b1, 32'hFFC, 32'h7777_0FFC, 1'b0, rd, er, lat);
    check("top_wr_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'hFFC, 32'h0, 1'b0, rd, er, lat);
    check("top_rd_rdata", rd, 32'h7777_0FFC);
    txn(0, 1'b1, 32'h20, 32'h55AA_55AA, 1'b0, rd, er, lat);
    txn(0, 1'b1, 32'h22, 32'h0000_1234, 1'b0, rd, er, lat);
    check("misal_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat);
    check("misal_kept", rd, 32'h55AA_55AA);

    // mem_req held high for 12 edges at LATENCY=1: pulses after edges 2,5,8,11.
    pulses    = 0;
    last_edge = -1;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (ready[0]) begin
        pulses++;
        check("burst_rdata", rdata[0], 32'hCAFE_F00D);
        if (last_edge < 0) check("burst_first", 32'(e), 32'd2);
        else               check("burst_gap", 32'(e - last_edge), 32'd3);
        last_edge = e;
      end
    end
    req[0] = 1'b0;
    check("burst_pulses", 32'(pulses), 32'd4);
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready[0]) pulses++;
    end
    check("burst_quiet", 32'(pulses), 32'd0);

    // Reset two edges into a LATENCY=3 write: no response and no write.
    txn(1, 1'b1, 32'h40, 32'h0000_0040, 1'b0, rd, er, lat);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'h9999_9999;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req[1] = 1'b0; we[1] = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 32'(ready[1]), 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready[1]) pulses++;
    end
    check("abort_quiet", 32'(pulses), 32'd0);
    txn(1, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, lat);
    check("abort_kept", rd, 32'h0000_0040);

`ifdef SCRATCHPAD_PERF_CNT_EN
    // The reset above cleared instance 0's counters.
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
    txn(0, 1'b1, 32'h14, 32'h1, 1'b0, rd, er, lat);
    txn(0, 1'b0, 32'h3, 32'h0, 1'b0, rd, er, lat);
    check("perf_rd", prd[0], 32'd2);
    check("perf_wr", pwr[0], 32'd1);
    check("perf_err", perr[0], 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
